// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive word path.
//   rx_state_e      assembler states (COLLECT / PUSH / WAIT_SPACE)
//   BYTE_BITS       width of one received UART character
//   bytes_per_word  number of bytes packed into a DATA_BITS-wide word
package uart_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,  // gathering bytes of the current word
    PUSH       = 2'd1,  // write strobe to the RX FIFO is high this cycle
    WAIT_SPACE = 2'd2   // completed word held until the FIFO has room
  } rx_state_e;

  function automatic int bytes_per_word(input int data_bits);
    return data_bits / BYTE_BITS;
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: inter-byte timeout counter for the RX word assembler.
// Instantiated only when UART_RX_TIMEOUT_EN is defined.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_clear    a byte was accepted this cycle; restarts the count
//   i_active   a partial word is held in COLLECT; counting enabled
//   o_expire   combinational: count has reached TIMEOUT_CYCLES-1 while active
module uart_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_active,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_expire = i_active && (count_q == LAST_COUNT);

  // An accepted byte on the expiry cycle also clears the count; the
  // assembler gives the byte priority over the discard.
  always_comb begin
    count_d = count_q;
    if (i_clear || o_expire) begin
      count_d = '0;
    end else if (i_active) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs received UART bytes LSB-first into DATA_BITS
// words and writes each completed word into the RX FIFO.
// Optional feature macro: UART_RX_TIMEOUT_EN (inter-byte timeout that
// discards a stale partial word after TIMEOUT_CYCLES idle cycles).
// Ports:
//   i_clk, i_reset  clock / synchronous active-high reset
//   i_rx_done       one-cycle pulse, i_rx_data valid
//   i_rx_data       received byte
//   i_fifo_full     RX FIFO cannot accept a write
//   o_fifo_wr       registered one-cycle write strobe
//   o_fifo_data     registered assembled word, holds last pushed word
//   o_overrun       one-cycle pulse: byte dropped while a word was pending
//   o_timeout       one-cycle pulse: partial word discarded (0 without macro)
//   o_busy          partial or pending word held
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_fifo_full,
  output logic                 o_fifo_wr,
  output logic [DATA_BITS-1:0] o_fifo_data,
  output logic                 o_overrun,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam int BYTES = bytes_per_word(DATA_BITS);
  localparam int IDX_W = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  // Word must hold at least two whole bytes; the timeout needs two counts.
  if ((DATA_BITS % BYTE_BITS != 0) || (DATA_BITS < 16) || (TIMEOUT_CYCLES < 2)) begin : g_cfg_err
    $error("uart_word_assembler: illegal DATA_BITS=%0d / TIMEOUT_CYCLES=%0d",
           DATA_BITS, TIMEOUT_CYCLES);
  end

  rx_state_e              state_q, state_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;
  logic                   fifo_wr_q, fifo_wr_d;
  logic [DATA_BITS-1:0]   fifo_data_q, fifo_data_d;
  logic                   overrun_q, overrun_d;

  logic [DATA_BITS-1:0]   word_next;
  logic                   byte_accept;
  logic                   expire;

  // Bytes are dropped only while a completed word is waiting for space;
  // in PUSH the word has already been copied to the output register.
  assign byte_accept = i_rx_done && (state_q != WAIT_SPACE);

  // Buffer contents with the incoming byte merged into its lane.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign word_next[gi*BYTE_BITS +: BYTE_BITS] =
      (byte_idx_q == IDX_W'(gi)) ? i_rx_data : buf_q[gi*BYTE_BITS +: BYTE_BITS];
  end

`ifdef UART_RX_TIMEOUT_EN
  uart_rx_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (byte_accept),
    .i_active ((state_q == COLLECT) && (byte_idx_q != '0)),
    .o_expire (expire)
  );
  // A byte arriving on the expiry cycle suppresses the discard.
  assign o_timeout = expire && !i_rx_done;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    overrun_d   = 1'b0;

    case (state_q)
      PUSH: state_d = COLLECT;
      WAIT_SPACE: begin
        overrun_d = i_rx_done;
        if (!i_fifo_full) begin
          state_d     = PUSH;
          fifo_wr_d   = 1'b1;
          fifo_data_d = buf_q;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (expire && !i_rx_done) begin
      byte_idx_d = '0;
    end

    if (byte_accept) begin
      buf_d = word_next;
      if (byte_idx_q == LAST_IDX) begin
        byte_idx_d = '0;
        if (i_fifo_full) begin
          state_d = WAIT_SPACE;
        end else begin
          state_d     = PUSH;
          fifo_wr_d   = 1'b1;
          fifo_data_d = word_next;
        end
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= COLLECT;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_fifo_wr   = fifo_wr_q;
  assign o_fifo_data = fifo_data_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (byte_idx_q != '0) || (state_q != COLLECT);

endmodule
